// File: rtl/seq_scan_ctrl_if.sv
// Word handshake between a producer and seq_scan_ctrl.
// Carries the valid/ready pair plus the data word and frame-end flag.
interface seq_scan_ctrl_if #(
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready
  );
endinterface

// File: rtl/seq_scan_ctrl.sv
// Serialises handshaked words MSB-first through a programmable
// overlapping pattern matcher with a saturating per-frame hit count.
module seq_scan_ctrl #(
  parameter int DATA_W  = 16,
  parameter int PAT_MAX = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(PAT_MAX + 1)
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               cfg_we,
  input  logic [PAT_MAX-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  seq_scan_ctrl_if.slave     in_if,
  output logic               busy,
  output logic               hit,
  output logic [CNT_W-1:0]   hit_cnt,
  output logic               frame_done
);

  localparam int BC_W = $clog2(DATA_W);

  localparam logic [LEN_W-1:0] PMAX =
    LEN_W'(PAT_MAX);
  localparam logic [LEN_W-1:0] DEF_LEN =
    LEN_W'(5);
  localparam logic [PAT_MAX-1:0] DEF_PAT =
    PAT_MAX'(5'b01110);
  localparam logic [CNT_W-1:0] CMAX =
    {CNT_W{1'b1}};
  localparam logic [BC_W-1:0] BC_TOP =
    BC_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state;
  state_t state_n;

  logic [DATA_W-1:0]  sreg;
  logic               last_q;
  logic [BC_W-1:0]    bcnt;
  logic [PAT_MAX-1:0] hist;
  logic [PAT_MAX-1:0] hist_n;
  logic [LEN_W-1:0]   fill;
  logic [LEN_W-1:0]   fill_n;
  logic               first_q;
  logic [PAT_MAX-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   len_clamp;
  logic [PAT_MAX-1:0] mask;
  logic               accept;
  logic               step;
  logic               match;
  logic               cfg_ok;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    step    = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_if.in_valid) begin
          accept  = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (bcnt == '0) begin
          state_n = last_q ? DONE : IDLE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign in_if.in_ready = (state == IDLE);
  assign busy           = (state != IDLE);
  assign frame_done     = (state == DONE);
  assign cfg_ok         = cfg_we && (state == IDLE);

  // Matching looks at the history as it will be after this bit.
  always_comb begin
    hist_n = {hist[PAT_MAX-2:0], sreg[DATA_W-1]};
    fill_n = (fill == PMAX) ? PMAX : fill + 1'b1;
    mask   = ~({PAT_MAX{1'b1}} << len_q);
    match  = (len_q != '0)
          && (((hist_n ^ pat_q) & mask) == '0)
          && (fill_n >= len_q);
    len_clamp = (cfg_len > PMAX) ? PMAX : cfg_len;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sreg    <= '0;
      last_q  <= 1'b0;
      bcnt    <= '0;
      hist    <= '0;
      fill    <= '0;
      first_q <= 1'b1;
      pat_q   <= DEF_PAT;
      len_q   <= DEF_LEN;
      hit     <= 1'b0;
      hit_cnt <= '0;
    end else begin
      hit <= step && match;
      if (cfg_ok) begin
        pat_q <= cfg_pattern;
        len_q <= len_clamp;
      end
      if (accept) begin
        sreg    <= in_if.in_data;
        last_q  <= in_if.in_last;
        bcnt    <= BC_TOP;
        first_q <= 1'b0;
        if (first_q) begin
          hit_cnt <= '0;
        end
      end
      if (step) begin
        sreg <= {sreg[DATA_W-2:0], 1'b0};
        bcnt <= bcnt - 1'b1;
        hist <= hist_n;
        fill <= fill_n;
        if (match && (hit_cnt != CMAX)) begin
          hit_cnt <= hit_cnt + 1'b1;
        end
      end
      if (state == DONE) begin
        hist    <= '0;
        fill    <= '0;
        first_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed and random frames for seq_scan_ctrl, checked bit by bit
// against a queue-based model of the scanned stream.
module tb_seq_scan_ctrl;

  localparam int DATA_W  = 16;
  localparam int PAT_MAX = 8;
  localparam int CNT_W   = 3;
  localparam int LEN_W   = 4;
  localparam int CSAT    = 7;

  logic             clk = 1'b0;
  logic             clr;
  logic             cfg_we;
  logic [PAT_MAX-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             busy;
  logic             hit;
  logic [CNT_W-1:0] hit_cnt;
  logic             frame_done;

  seq_scan_ctrl_if #(.DATA_W(DATA_W)) bus ();

  seq_scan_ctrl #(
    .DATA_W (DATA_W),
    .PAT_MAX(PAT_MAX),
    .CNT_W  (CNT_W),
    .LEN_W  (LEN_W)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .cfg_we     (cfg_we),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .in_if      (bus),
    .busy       (busy),
    .hit        (hit),
    .hit_cnt    (hit_cnt),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int total;
  int bad;

  bit         q[$];
  logic [7:0] m_pat;
  int         m_len;
  int         m_cnt;
  bit         m_first;

  function automatic bit m_hit();
    int n;
    n = q.size();
    if (m_len == 0 || n < m_len) return 1'b0;
    for (int j = 0; j < m_len; j++) begin
      if (q[n - m_len + j] != m_pat[m_len - 1 - j]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    q.delete();
    m_pat   = 8'b0000_1110;
    m_len   = 5;
    m_cnt   = 0;
    m_first = 1'b1;
  endtask

  task automatic do_reset();
    clr = 1'b0;
    #1;
    chk("rst_hit", hit, 1'b0);
    chk("rst_cnt", hit_cnt, 0);
    chk("rst_done", frame_done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_done_hold", frame_done, 1'b0);
    clr = 1'b1;
    m_reset();
  endtask

  task automatic cfg_write(input logic [7:0] pat, input int len);
    cfg_pattern = pat;
    cfg_len     = LEN_W'(len);
    cfg_we      = 1'b1;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    m_pat  = pat;
    m_len  = (len > PAT_MAX) ? PAT_MAX : len;
  endtask

  task automatic send_word(input logic [15:0] d,
                           input bit last,
                           input int cfg_at,
                           input int rst_at);
    bit e;
    chk("in_ready", bus.in_ready, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    if (m_first) begin
      m_cnt   = 0;
      m_first = 1'b0;
    end
    chk("busy_acc", busy, 1'b1);
    chk("cnt_acc", hit_cnt, m_cnt);
    for (int i = 0; i < DATA_W; i++) begin
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
      q.push_back(d[DATA_W - 1 - i]);
      e = m_hit();
      if (e && m_cnt < CSAT) m_cnt++;
      chk("hit", hit, e);
      chk("cnt", hit_cnt, m_cnt);
      if (i == rst_at) begin
        do_reset();
        return;
      end
      if (i == cfg_at) begin
        cfg_pattern = 8'h01;
        cfg_len     = 4'd1;
        cfg_we      = 1'b1;
      end
    end
    chk("done", frame_done, last);
    if (last) begin
      @(posedge clk);
      #1;
      chk("done_end", frame_done, 1'b0);
      chk("hit_end", hit, 1'b0);
      chk("cnt_hold", hit_cnt, m_cnt);
      q.delete();
      m_first = 1'b1;
    end
  endtask

  initial begin
    int nw;
    logic [15:0] w;
    total        = 0;
    bad          = 0;
    clr          = 1'b1;
    cfg_we       = 1'b0;
    cfg_pattern  = '0;
    cfg_len      = '0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    m_reset();
    #2;
    do_reset();

    send_word(16'h7777, 1'b1, -1, -1);
    chk("t_7777", hit_cnt, 3);

    send_word(16'h0007, 1'b0, -1, -1);
    send_word(16'h0000, 1'b1, -1, -1);
    chk("t_cross", hit_cnt, 1);

    send_word(16'h0007, 1'b1, -1, -1);
    send_word(16'h0000, 1'b1, -1, -1);
    chk("t_isolate", hit_cnt, 0);

    cfg_write(8'h01, 1);
    send_word(16'hFFFF, 1'b1, -1, -1);
    chk("t_sat", hit_cnt, 7);

    cfg_write(8'h05, 3);
    send_word(16'h7777, 1'b1, -1, 6);
    send_word(16'h7777, 1'b1, -1, -1);
    chk("t_after_rst", hit_cnt, 3);

    send_word(16'h7777, 1'b1, 5, -1);
    chk("t_cfg_busy", hit_cnt, 3);
    send_word(16'h7777, 1'b1, -1, -1);
    chk("t_cfg_kept", hit_cnt, 3);

    cfg_write(8'h77, 15);
    send_word(16'h7777, 1'b1, -1, -1);
    chk("t_clamp", hit_cnt, 3);

    cfg_write(8'hFF, 0);
    send_word(16'hFFFF, 1'b1, -1, -1);
    chk("t_len0", hit_cnt, 0);

    for (int f = 0; f < 8; f++) begin
      cfg_write(8'($urandom), $urandom_range(1, 15));
      nw = $urandom_range(1, 3);
      for (int k = 0; k < nw; k++) begin
        w = 16'($urandom);
        if (f[0]) w = w | (w << 1);
        send_word(w, k == nw - 1, -1, -1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_scan_ctrl.md
# seq_scan_ctrl

Sequencing controller for the serial pattern-detection datapath. Accepts parallel words over a valid/ready handshake, serialises them MSB-first one bit per cycle through a programmable overlapping pattern matcher, and reports per-match pulses, a saturating match count and an end-of-frame strobe. History carries across words within a frame. It clears at frame end, so a single detector engine can scan multi-word frames under software-configured patterns.

## Interface
- DATA_W, 16, input word width (≥2)
- PAT_MAX, 8, maximum pattern length in bits
- CNT_W, 8, match-counter width
- LEN_W, $clog2(PAT_MAX+1), width of cfg_len
- clk  input  1  sole clock, rising edge
- clr  input  1  reset; one clock; reset is asynchronous and active-low
- cfg_we  input  1  pattern/length write strobe; honoured only in IDLE
- cfg_pattern  input  PAT_MAX  pattern, right-aligned; bit [len-1] is matched first
- cfg_len  input  LEN_W  pattern length
- in_valid  input  1  word available
- in_ready  output  1  block can accept a word
- in_data  input  DATA_W  word; bit [DATA_W-1] is scanned first
- in_last  input  1  word is the final word of a frame; sampled with in_data
- busy  output  1  word being scanned (state ≠ IDLE)
- hit  output  1  one-cycle pulse per match
- hit_cnt  output  CNT_W  matches in current/last frame, saturating
- frame_done  output  1  one-cycle pulse; hit_cnt is final

## Operation
- FSM states:
  - IDLE: in_ready=1. On in_valid & in_ready, load the shift register with in_data, latch in_last, set bit counter to DATA_W-1, then go to SHIFT. If the previous frame ended (first-word flag set), clear hit_cnt on the same edge.
  - SHIFT: consume one bit per cycle, hist <= {hist[PAT_MAX-2:0], bit}, and fill <= min(fill+1, PAT_MAX). After the bit with counter==0, go to DONE if in_last was latched, else to IDLE.
  - DONE: one cycle. frame_done=1, hist and fill are cleared, and the first-word flag is set. Then go to IDLE.
- Match rule: a match occurs when next-hist[len-1:0] == pattern[len-1:0] and next-fill ≥ len. Matches may overlap.
- Effective len: cfg_len > PAT_MAX is clamped to PAT_MAX. cfg_len == 0 never matches.
- Config:
  - cfg_we outside IDLE is ignored, with no partial update.
  - A write in IDLE applies from the next bit scanned. It does not clear hist.
- hit_cnt increments on each match and saturates at 2^CNT_W-1. It holds its value from DONE until the first word of the next frame is accepted.
- Reset values:
  - state IDLE, hist 0, fill 0, first-word flag 1
  - hit 0, hit_cnt 0, frame_done 0, busy 0, in_ready 1
  - pattern PAT_MAX'b0…01110, len 5 (legacy 01110 detect)
- Reset mid-operation: an in-flight word is discarded and no frame_done is produced. Configuration returns to the default.

## Timing
- hit and hit_cnt are registered. Both change on the same edge that consumes the matching bit, so they are visible in the following cycle.
- Per-word occupancy is DATA_W SHIFT cycles, then either 1 IDLE cycle (accept) or DONE + IDLE. Sustained throughput is DATA_W bits per DATA_W+1 cycles within a frame.
- Accept-to-first-bit latency is 1 cycle: the first bit is consumed on the first SHIFT edge.
- frame_done is high in the cycle after the last bit's edge. The last bit's hit is visible in that same cycle, and hit_cnt already includes it.
- in_ready is a Moore output (state==IDLE), so it has no combinational path from in_valid.
- in_valid held with in_ready=0: the word is not consumed and in_data must be held stable.

## Test plan
- Default config, single word 16'h7777 with in_last=1 -> 3 hit pulses, after bits 4, 8 and 12 (0-based scan index) -> frame_done with hit_cnt=3.
- Cross-word continuity: 16'h0007 (in_last=0), then 16'h0000 (in_last=1) -> exactly one hit, on bit 0 of word 2 -> frame_done with hit_cnt=1.
- Frame isolation: frame A = 16'h0007 (in_last=1), then frame B = 16'h0000 -> hit_cnt=0 at frame B's frame_done (history cleared). hit_cnt still reads 0 in the cycle after frame B's word is accepted.
- Reconfig and saturation (CNT_W=3): cfg pattern 1'b1, len 1, word 16'hFFFF with in_last=1 -> 16 hits; hit_cnt stops at 7.
- Config ignored while busy: cfg_we with len=1, pattern=1 pulsed mid-SHIFT on 16'h7777 -> still 3 hits and default config retained. Clamp check: cfg_len=15 behaves as 8; cfg_len=0 gives 0 hits.
- Reset mid-SHIFT (clr low at bit 6 of 16'h7777) -> outputs immediately at reset values, no frame_done. After release, a new 16'h7777 frame yields hit_cnt=3.
